// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared dsm constants and CIC decimator sizing helpers
package dsm_pkg;

  localparam int DSM_VIN_W     = 20;
  localparam int CIC_ORDER     = 3;
  localparam int CIC_DECIM_LOG = 6;

  // Bit growth of a sinc^N filter with ratio 2**decim_log, plus one bit so R**N itself fits
  function automatic int cic_acc_width(input int order, input int decim_log);
    return order * decim_log + 1;
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// rtl/cic_integrator.sv - single enable-gated CIC integrator stage (modulo 2**AW)
module cic_integrator #(
  parameter int AW = 19
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] acc,
  output logic [AW-1:0] acc_next
);

  assign acc_next = acc + din;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/dsm_decimator.sv
// rtl/dsm_decimator.sv - sinc^N CIC decimator recovering unsigned samples from the dsm bitstream
// Define DSM_DEC_CLIP_EN to saturate full-scale results instead of letting them wrap.
module dsm_decimator
  import dsm_pkg::*;
#(
  parameter int ORDER     = CIC_ORDER,
  parameter int DECIM_LOG = CIC_DECIM_LOG,
  parameter int OUT_W     = DSM_VIN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm,
  output logic [OUT_W-1:0] vout,
  output logic             vout_valid
);

  localparam int AW = cic_acc_width(ORDER, DECIM_LOG);
  localparam int SH = OUT_W - ORDER * DECIM_LOG;

  logic [ORDER-1:0][AW-1:0] integ;
  logic [ORDER-1:0][AW-1:0] integ_next;
  logic [ORDER-1:0][AW-1:0] integ_din;
  logic [ORDER-1:0][AW-1:0] dly;
  logic [ORDER-1:0][AW-1:0] dly_next;
  logic [DECIM_LOG-1:0]     count;
  logic [2:0]               warm;
  logic                     tick;
  logic                     warm_done;
  logic [AW-1:0]            comb_out;
  logic [OUT_W:0]           norm;
  logic [OUT_W-1:0]         result;

  assign integ_din[0] = AW'(pwm);

  genvar k;
  generate
    for (k = 0; k < ORDER; k++) begin : g_integ
      if (k > 0) begin : g_link
        assign integ_din[k] = integ[k-1];
      end
      cic_integrator #(.AW(AW)) u_integ (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .din      (integ_din[k]),
        .acc      (integ[k]),
        .acc_next (integ_next[k])
      );
    end
  endgenerate

  assign tick      = en & (count == {DECIM_LOG{1'b1}});
  assign warm_done = (warm == 3'(ORDER - 1));

  // The comb chain sees the last integrator's value after this cycle's update
  always_comb begin
    logic [AW-1:0] stage;
    stage    = integ_next[ORDER-1];
    dly_next = '0;
    for (int i = 0; i < ORDER; i++) begin
      dly_next[i] = stage;
      stage       = stage - dly[i];
    end
    comb_out = stage;
  end

  assign norm = (OUT_W + 1)'(comb_out) << SH;

`ifdef DSM_DEC_CLIP_EN
  assign result = norm[OUT_W] ? {OUT_W{1'b1}} : norm[OUT_W-1:0];
`else
  assign result = norm[OUT_W-1:0];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      dly        <= '0;
      warm       <= '0;
      vout       <= '0;
      vout_valid <= 1'b0;
    end else begin
      vout_valid <= 1'b0;
      if (en) begin
        count <= count + 1'b1;
      end
      if (tick) begin
        dly <= dly_next;
        // The first ORDER-1 ticks only prime the comb delays
        if (warm_done) begin
          vout       <= result;
          vout_valid <= 1'b1;
        end else begin
          warm <= warm + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsm_decimator.sv
// tb/tb_dsm_decimator.sv - randomized self-checking bench for dsm_decimator against a sinc^N convolution model
module tb_dsm_decimator;

  localparam int ORDER = 3;
  localparam int DL    = 6;
  localparam int R     = 64;
  localparam int OUT_W = 20;
  localparam int HL    = ORDER * (R - 1) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              en    = 1'b0;
  logic              pwm   = 1'b0;
  logic [OUT_W-1:0]  vout;
  logic              vout_valid;

  int total = 0;
  int bad   = 0;

  longint h [HL];
  bit     hist [$];
  longint m_vout;
  bit     m_valid;
  int     edges;
  int     first_valid_edge;
  int     prev_valid_edge;
  int     exp_spacing;
  longint last_vout;

  dsm_decimator dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .pwm        (pwm),
    .vout       (vout),
    .vout_valid (vout_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Ideal decimated output: impulse response of the box filter cubed, applied to enabled samples
  function automatic longint model_out(input int n);
    longint s;
    int idx;
    s = 0;
    for (int j = 0; j < HL; j++) begin
      idx = n - (ORDER - 1) - j;
      if (idx >= 0 && hist[idx]) s += h[j];
    end
    s = s <<< (OUT_W - ORDER * DL);
`ifdef DSM_DEC_CLIP_EN
    if (s >= (64'd1 << OUT_W)) s = (64'd1 << OUT_W) - 1;
`else
    s = s % (64'd1 << OUT_W);
`endif
    return s;
  endfunction

  task automatic step(input bit r, input bit e, input bit p);
    int n;
    reset = r;
    en    = e;
    pwm   = p;
    @(posedge clock);
    if (r) begin
      hist.delete();
      m_vout           = 0;
      m_valid          = 0;
      edges            = 0;
      prev_valid_edge  = -1;
      first_valid_edge = -1;
    end else begin
      edges++;
      m_valid = 0;
      if (e) begin
        hist.push_back(p);
        n = hist.size();
        if ((n % R) == 0 && (n / R) >= ORDER) begin
          m_valid = 1;
          m_vout  = model_out(n - 1);
        end
      end
    end
    @(negedge clock);
    check("valid", vout_valid, m_valid);
    check("vout", vout, m_vout);
    if (vout_valid) begin
      last_vout = vout;
      if (first_valid_edge < 0) first_valid_edge = edges;
      if (prev_valid_edge >= 0 && exp_spacing > 0) check("spacing", edges - prev_valid_edge, exp_spacing);
      prev_valid_edge = edges;
    end
  endtask

  // mode: 0 zeros, 1 ones, 2 1010.., 3 1000.., 4 random, 5 first-order dsm of vin
  task automatic run_phase(input int mode, input int ncyc, input int en_div, input bit rand_en,
                           input bit do_reset, input int vin);
    int  k;
    bit  e;
    bit  p;
    longint acc;
    longint sum;
    if (do_reset) for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    exp_spacing = rand_en ? 0 : R * en_div;
    k   = 0;
    acc = 0;
    for (int c = 0; c < ncyc; c++) begin
      e = rand_en ? bit'($urandom_range(0, 1)) : ((c % en_div) == 0);
      p = bit'($urandom_range(0, 1));
      if (e) begin
        case (mode)
          0: p = 1'b0;
          1: p = 1'b1;
          2: p = (k % 2) == 0;
          3: p = (k % 4) == 0;
          5: begin
            sum = acc + vin;
            p   = sum >= (64'd1 << OUT_W);
            acc = sum % (64'd1 << OUT_W);
          end
          default: ;
        endcase
        k++;
      end
      step(1'b0, e, p);
    end
  endtask

  initial begin
    longint tmp [HL];
    bit fs_ok;
    for (int i = 0; i < HL; i++) h[i] = (i == 0);
    for (int o = 0; o < ORDER; o++) begin
      for (int i = 0; i < HL; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < R; j++) if (i - j >= 0) tmp[i] += h[i - j];
      end
      for (int i = 0; i < HL; i++) h[i] = tmp[i];
    end
    last_vout = -1;

    run_phase(0, 600, 1, 1'b0, 1'b1, 0);
    check("first_valid_latency", first_valid_edge, ORDER * R);
    check("zeros_vout", last_vout, 0);

    run_phase(1, 600, 1, 1'b0, 1'b1, 0);
`ifdef DSM_DEC_CLIP_EN
    check("full_scale_vout", last_vout, 20'hFFFFF);
`else
    check("full_scale_vout", last_vout, 20'h00000);
`endif

    run_phase(2, 600, 1, 1'b0, 1'b1, 0);
    check("half_vout", last_vout, 20'h80000);

    run_phase(3, 600, 1, 1'b0, 1'b1, 0);
    check("quarter_vout", last_vout, 20'h40000);

    run_phase(2, 192 * 5 + 10, 3, 1'b0, 1'b1, 0);
    check("en_third_vout", last_vout, 20'h80000);

    run_phase(2, R * 4 + 30, 1, 1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1);
    check("mid_reset_vout", vout, 0);
    check("mid_reset_valid", vout_valid, 0);
    last_vout = -1;
    run_phase(2, 400, 1, 1'b0, 1'b0, 0);
    check("post_reset_latency", first_valid_edge, ORDER * R);
    check("post_reset_vout", last_vout, 20'h80000);

    run_phase(4, 1500, 1, 1'b1, 1'b1, 0);
    run_phase(4, 800, 1, 1'b0, 1'b1, 0);

    run_phase(5, 700, 1, 1'b0, 1'b1, 20'h40000);
    fs_ok = (last_vout >= 20'h40000 - 20'h400) && (last_vout <= 20'h40000 + 20'h400);
    check("loopback_range", fs_ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
